// File: rtl/r22sdf_bitrev_reorder.sv
// Bit-reversed to natural-order reorder buffer for the output of an R2^2 SDF FFT.
//
// Incoming samples arrive in bit-reversed index order. Each accepted sample is
// written at bitrev(wcnt) in the current write bank. When a full frame has been
// written, that bank is handed to the reader, which streams addresses 0..N-1 out
// of it in natural order while the writer fills the other bank (ping-pong).
//
// Ports:
//   sys_clk            clock, all state on the rising edge
//   sys_nrst           synchronous active-low reset, overrides sys_en
//   sys_en             global advance strobe; nothing but reset changes state when low
//   din_valid/din_sof  input sample strobe / first-sample-of-frame marker
//   din_r/din_i        input sample, bit-reversed index order
//   dout_r/dout_i      output sample, natural index order (registered)
//   dout_valid         one cycle per output sample
//   dout_sof           with dout_valid on output index 0
//   frame_drop         one-cycle pulse when a partial input frame is discarded
module r22sdf_bitrev_reorder #(
  parameter int unsigned data_resolution = 16,
  parameter int unsigned fft_length      = 1024
) (
  input  logic                       sys_clk,
  input  logic                       sys_nrst,
  input  logic                       sys_en,
  input  logic                       din_valid,
  input  logic                       din_sof,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i,
  output logic                       dout_valid,
  output logic                       dout_sof,
  output logic                       frame_drop
);

  localparam int unsigned AW = $clog2(fft_length);
  localparam int unsigned DW = 2 * data_resolution;
  localparam logic [AW-1:0] LastIdx = AW'(fft_length - 1);

  typedef enum logic {StIdle, StRead} rd_state_e;

  // Both banks in one array; the MSB of the address selects the bank.
  logic [DW-1:0] mem [2*fft_length];

  logic [AW-1:0]              wcnt_q, rcnt_q;
  logic                       wbank_q, rbank_q, pending_q;
  rd_state_e                  state_q;
  logic [data_resolution-1:0] dout_r_q, dout_i_q;
  logic                       valid_q, sof_q, drop_q;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) begin
      r[b] = a[AW-1-b];
    end
    return r;
  endfunction

  logic          accept, frame_done, issue, last_issue;
  logic [AW-1:0] waddr;

  always_comb begin
    accept     = sys_en & din_valid;
    // A sof sample restarts the frame at index 0, so it never completes one.
    frame_done = accept & ~din_sof & (wcnt_q == LastIdx);
    issue      = sys_en & (state_q == StRead);
    last_issue = issue & (rcnt_q == LastIdx);
    waddr      = din_sof ? '0 : bitrev(wcnt_q);
  end

  // Storage is deliberately not reset.
  always_ff @(posedge sys_clk) begin
    if (sys_nrst && accept) begin
      mem[{wbank_q, waddr}] <= {din_r, din_i};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_nrst) begin
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      pending_q <= 1'b0;
      state_q   <= StIdle;
      dout_r_q  <= '0;
      dout_i_q  <= '0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else if (sys_en) begin
      valid_q <= issue;
      sof_q   <= issue & (rcnt_q == '0);
      drop_q  <= accept & din_sof & (wcnt_q != '0);
      if (issue) begin
        {dout_r_q, dout_i_q} <= mem[{rbank_q, rcnt_q}];
      end

      if (accept) begin
        wcnt_q <= din_sof ? AW'(1) : wcnt_q + AW'(1);
        if (frame_done) begin
          wbank_q <= ~wbank_q;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (frame_done) begin
            state_q <= StRead;
            rcnt_q  <= '0;
            rbank_q <= wbank_q;
          end
        end
        StRead: begin
          rcnt_q <= rcnt_q + AW'(1);
          if (last_issue) begin
            if (pending_q || frame_done) begin
              // The queued frame is always in the bank opposite the one just read.
              rcnt_q    <= '0;
              rbank_q   <= ~rbank_q;
              pending_q <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else if (frame_done) begin
            pending_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Registered strobes are held while sys_en is low and presented on the next
  // enabled cycle, so each sample is seen exactly once by an enabled consumer.
  always_comb begin
    dout_r     = dout_r_q;
    dout_i     = dout_i_q;
    dout_valid = valid_q & sys_en;
    dout_sof   = sof_q & sys_en;
    frame_drop = drop_q & sys_en;
  end

endmodule

// File: tb/tb_r22sdf_bitrev_reorder.sv
module tb_r22sdf_bitrev_reorder;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nrst, en, vld, sof;
  logic [W-1:0] dr, di, o_r, o_i;
  logic         o_v, o_sof, drop;

  logic         en2, vld2, sof2;
  logic [W-1:0] dr2, di2, o2_r, o2_i;
  logic         o2_v, o2_sof, drop2;

  r22sdf_bitrev_reorder #(.data_resolution(W), .fft_length(16)) dut16 (
    .sys_clk(clk), .sys_nrst(nrst), .sys_en(en), .din_valid(vld), .din_sof(sof),
    .din_r(dr), .din_i(di), .dout_r(o_r), .dout_i(o_i), .dout_valid(o_v),
    .dout_sof(o_sof), .frame_drop(drop)
  );

  r22sdf_bitrev_reorder #(.data_resolution(W), .fft_length(1024)) dut1k (
    .sys_clk(clk), .sys_nrst(nrst), .sys_en(en2), .din_valid(vld2), .din_sof(sof2),
    .din_r(dr2), .din_i(di2), .dout_r(o2_r), .dout_i(o2_i), .dout_valid(o2_v),
    .dout_sof(o2_sof), .frame_drop(drop2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Scoreboard for dut16: expected natural-order outputs.
  logic [W-1:0] q_r[$], q_i[$];
  logic         q_sof[$];
  logic [W-1:0] fr_r[16], fr_i[16];
  int           wm     = 0;
  int           n_drop = 0;
  bit           mon_on = 0;
  logic [W-1:0] er, ei;
  logic         es;

  logic [W-1:0] ref_r[1024], ref_i[1024];

  function automatic int unsigned brev(input int unsigned x, input int unsigned bits);
    int unsigned r = 0;
    for (int b = 0; b < bits; b++) if (x[b]) r |= (1 << (bits - 1 - b));
    return r;
  endfunction

  // Frame model: arrival k carries bin bitrev(k); output n is the arrival bitrev(n).
  task automatic model_accept(input logic s, input logic [W-1:0] r, input logic [W-1:0] i);
    if (s) wm = 0;
    fr_r[wm] = r;
    fr_i[wm] = i;
    if (wm == 15) begin
      for (int n = 0; n < 16; n++) begin
        q_r.push_back(fr_r[brev(n, 4)]);
        q_i.push_back(fr_i[brev(n, 4)]);
        q_sof.push_back(n == 0);
      end
      wm = 0;
    end else begin
      wm++;
    end
  endtask

  task automatic send(input logic s, input logic [W-1:0] r, input logic [W-1:0] i);
    en = 1'b1; vld = 1'b1; sof = s; dr = r; di = i;
    model_accept(s, r, i);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    vld = 1'b0; sof = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int c = 0;
    vld = 1'b0; sof = 1'b0;
    while (q_r.size() != 0 && c < 400) begin @(posedge clk); #1; c++; end
    idle(20);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (!en) begin
        total++;
        if ({o_v, o_sof, drop} !== 3'b000) begin
          bad++;
          $display("FAIL en_low_quiet: valid/sof/drop=%b want 000", {o_v, o_sof, drop});
        end
      end
      if (drop === 1'b1) n_drop++;
      if (o_v === 1'b1) begin
        total++;
        if (q_r.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: dout_r=%0d dout_i=%0d, nothing expected", o_r, o_i);
        end else begin
          er = q_r.pop_front(); ei = q_i.pop_front(); es = q_sof.pop_front();
          if ({o_r, o_i, o_sof} !== {er, ei, es}) begin
            bad++;
            $display("FAIL sample: r=%0d i=%0d sof=%b want r=%0d i=%0d sof=%b",
                     o_r, o_i, o_sof, er, ei, es);
          end
        end
      end
    end
  end

  task automatic test_reset();
    nrst = 1'b0; en = 1'b0; vld = 1'b0; sof = 1'b0; dr = '0; di = '0;
    en2 = 1'b0; vld2 = 1'b0; sof2 = 1'b0; dr2 = '0; di2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({o_r, o_i, o2_r, o2_i} !== '0) begin
      bad++;
      $display("FAIL reset_data_en_low: r=%0d i=%0d r2=%0d i2=%0d want 0", o_r, o_i, o2_r, o2_i);
    end
    en = 1'b1; en2 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({o_v, o_sof, drop} !== 3'b000) begin
      bad++;
      $display("FAIL reset_strobes: valid/sof/drop=%b want 000", {o_v, o_sof, drop});
    end
    total++;
    if ({o2_v, o2_sof, drop2} !== 3'b000) begin
      bad++;
      $display("FAIL reset_strobes_1k: valid/sof/drop=%b want 000", {o2_v, o2_sof, drop2});
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    mon_on = 1;
    idle(2);
  endtask

  task automatic test_bitrev();
    int t_last;
    int c = 0;
    for (int k = 0; k < 16; k++) send(k == 0, W'(k), W'(16'hF000 + k));
    t_last = cyc - 1;
    vld = 1'b0; sof = 1'b0;
    do begin @(negedge clk); c++; end while (o_v !== 1'b1 && c < 50);
    total++;
    if (cyc !== t_last + 2) begin
      bad++;
      $display("FAIL latency: first output at T+%0d want T+2", cyc - t_last);
    end
    total++;
    if ({o_r, o_sof} !== {W'(0), 1'b1}) begin
      bad++;
      $display("FAIL first_output: r=%0d sof=%b want r=0 sof=1", o_r, o_sof);
    end
    @(posedge clk); #1;
    wait_drain();
    total++;
    if (q_r.size() !== 0) begin
      bad++;
      $display("FAIL bitrev_drain: %0d outputs missing want 0", q_r.size());
    end
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    fork
      begin
        for (int k = 0; k < 32; k++) begin
          if (k < 16) send(k == 0, W'(100 + k), W'(100 + k) ^ 16'h8000);
          else        send(k == 16, W'(200 + k - 16), W'(200 + k - 16) ^ 16'h8000);
        end
        vld = 1'b0; sof = 1'b0;
      end
      begin
        int c = 0;
        do begin @(negedge clk); c++; end while (o_v !== 1'b1 && c < 100);
        for (int n = 0; n < 32; n++) begin
          if (o_v !== 1'b1) gaps++;
          @(negedge clk);
        end
        total++;
        if (o_v !== 1'b0) begin
          bad++;
          $display("FAIL b2b_end: valid=%b after 32 outputs want 0", o_v);
        end
      end
    join
    total++;
    if (gaps !== 0) begin
      bad++;
      $display("FAIL b2b_gaps: %0d gap cycles want 0", gaps);
    end
    wait_drain();
    total++;
    if (q_r.size() !== 0) begin
      bad++;
      $display("FAIL b2b_drain: %0d outputs missing want 0", q_r.size());
    end
  endtask

  task automatic test_en_toggle();
    logic [W-1:0] held_r, held_i;
    held_r = '0; held_i = '0;
    for (int p = 0; p < 60; p++) begin
      en = 1'b1;
      if (p < 16) begin
        vld = 1'b1; sof = (p == 0); dr = W'(500 + p); di = W'(16'h8000 + p);
        model_accept(sof, dr, di);
      end else begin
        vld = 1'b0; sof = 1'b0;
      end
      @(negedge clk);
      if (p > 0) begin
        total++;
        if ({o_r, o_i} !== {held_r, held_i}) begin
          bad++;
          $display("FAIL en_hold: r=%0d i=%0d want r=%0d i=%0d", o_r, o_i, held_r, held_i);
        end
      end
      @(posedge clk); #1;
      // vld/sof left as they were: must be ignored while disabled
      en = 1'b0;
      @(negedge clk);
      held_r = o_r; held_i = o_i;
      @(posedge clk); #1;
    end
    en = 1'b1;
    wait_drain();
    total++;
    if (q_r.size() !== 0) begin
      bad++;
      $display("FAIL en_drain: %0d outputs missing want 0", q_r.size());
    end
  endtask

  task automatic test_resync();
    int d0 = n_drop;
    for (int k = 0; k < 5; k++) send(k == 0, W'(50 + k), W'(60 + k));
    send(1'b1, W'(300), W'(400));
    vld = 1'b0; sof = 1'b0;
    @(negedge clk);
    total++;
    if (drop !== 1'b1) begin
      bad++;
      $display("FAIL drop_pulse: frame_drop=%b want 1", drop);
    end
    @(posedge clk); #1;
    for (int k = 1; k < 16; k++) send(1'b0, W'(300 + k), W'(400 + k));
    wait_drain();
    total++;
    if (n_drop - d0 !== 1) begin
      bad++;
      $display("FAIL drop_count: %0d pulses want 1", n_drop - d0);
    end
    total++;
    if (q_r.size() !== 0) begin
      bad++;
      $display("FAIL resync_drain: %0d outputs missing want 0", q_r.size());
    end
  endtask

  task automatic test_reset_mid_read();
    int cnt = 0;
    int c = 0;
    for (int k = 0; k < 16; k++) send(k == 0, W'(700 + k), W'(800 + k));
    vld = 1'b0; sof = 1'b0;
    while (cnt < 8 && c < 100) begin
      @(negedge clk); c++;
      if (o_v === 1'b1) cnt++;
    end
    total++;
    if (cnt !== 8) begin
      bad++;
      $display("FAIL reach_idx7: saw %0d outputs want 8", cnt);
    end
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    total++;
    if ({o_v, o_r, o_i} !== {1'b0, W'(0), W'(0)}) begin
      bad++;
      $display("FAIL mid_reset: valid=%b r=%0d i=%0d want 0 0 0", o_v, o_r, o_i);
    end
    q_r.delete(); q_i.delete(); q_sof.delete();
    wm = 0;
    @(posedge clk); #1;
    idle(40);
    for (int k = 0; k < 16; k++) send(k == 0, W'(900 + k), W'(950 + k));
    wait_drain();
    total++;
    if (q_r.size() !== 0) begin
      bad++;
      $display("FAIL post_reset_drain: %0d outputs missing want 0", q_r.size());
    end
  endtask

  task automatic test_random_1k();
    for (int k = 0; k < 1024; k++) begin
      ref_r[k] = W'($urandom);
      ref_i[k] = W'($urandom);
    end
    fork
      begin
        for (int k = 0; k < 1024; k++) begin
          en2 = 1'b1; vld2 = 1'b1; sof2 = (k == 0); dr2 = ref_r[k]; di2 = ref_i[k];
          @(posedge clk); #1;
        end
        vld2 = 1'b0; sof2 = 1'b0;
      end
      begin
        int c = 0;
        logic [W-1:0] xr, xi;
        logic         xs;
        do begin @(negedge clk); c++; end while (o2_v !== 1'b1 && c < 3000);
        for (int n = 0; n < 1024; n++) begin
          xr = ref_r[brev(n, 10)];
          xi = ref_i[brev(n, 10)];
          xs = (n == 0);
          total++;
          if ({o2_v, o2_sof, o2_r, o2_i} !== {1'b1, xs, xr, xi}) begin
            bad++;
            $display("FAIL rand1k[%0d]: v=%b sof=%b r=%h i=%h want v=1 sof=%b r=%h i=%h",
                     n, o2_v, o2_sof, o2_r, o2_i, xs, xr, xi);
          end
          @(negedge clk);
        end
        total++;
        if ({o2_v, drop2} !== 2'b00) begin
          bad++;
          $display("FAIL rand1k_end: valid/drop=%b want 00", {o2_v, drop2});
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_bitrev();
    test_back_to_back();
    test_en_toggle();
    test_resync();
    test_reset_mid_read();
    test_random_1k();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/r22sdf_bitrev_reorder.md
R22SDF_BITREV_REORDER -- requirements
Module: r22sdf_bitrev_reorder

Interface
REQ-001 The block SHALL have parameter data_resolution, default 16, the width of each real/imaginary sample.
REQ-002 The block SHALL have parameter fft_length, default 1024, the frame length; a power of 2 and at least 4; AW = log2(fft_length).
REQ-003 The block SHALL have port sys_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port sys_nrst, input, 1 bit, the reset; synchronous and active-low.
REQ-005 The block SHALL have port sys_en, input, 1 bit, the global advance strobe; no state changes when low, except reset.
REQ-006 The block SHALL have port din_valid, input, 1 bit, marking an FFT output sample present on din_r/din_i.
REQ-007 The block SHALL have port din_sof, input, 1 bit, marking the first sample of a frame; qualified by din_valid.
REQ-008 The block SHALL have ports din_r and din_i, input, data_resolution bits each, the FFT result in bit-reversed index order.
REQ-009 The block SHALL have ports dout_r and dout_i, output, data_resolution bits each, the result in natural index order 0..fft_length-1.
REQ-010 The block SHALL have port dout_valid, output, 1 bit, high for exactly one cycle per output sample.
REQ-011 The block SHALL have port dout_sof, output, 1 bit, high together with dout_valid on output index 0.
REQ-012 The block SHALL have port frame_drop, output, 1 bit, a one-cycle pulse when a partial input frame is discarded.

Function
REQ-013 Accept condition: a sample SHALL be accepted on a cycle when sys_en=1 and din_valid=1.
REQ-014 Storage SHALL be two banks, each fft_length x (2*data_resolution): a write bank and a read bank (ping-pong).
REQ-015 Write counter wcnt (AW bits) SHALL write each accepted sample at bitrev(wcnt) in the write bank; bitrev reverses all AW bits.
REQ-016 wcnt SHALL increment on each accepted sample and wrap from fft_length-1 to 0.
REQ-017 Frame complete: on acceptance at wcnt=fft_length-1, the write-bank select SHALL toggle and the filled bank SHALL be handed to the reader.
REQ-018 Resync: an accepted sample with din_sof=1 SHALL be written at address 0 and set wcnt to 1.
REQ-019 Resync with wcnt!=0: the partial frame SHALL be discarded with no bank toggle, and frame_drop SHALL pulse the following cycle.
REQ-020 Reader FSM SHALL have states IDLE and READ; IDLE->READ on frame complete, with rcnt=0.
REQ-021 In READ with sys_en=1, the reader SHALL issue read address rcnt and increment rcnt.
REQ-022 After issuing rcnt=fft_length-1, the reader SHALL go to IDLE, unless a new frame completed, in which case it goes to READ with rcnt=0 on the other bank.
REQ-023 Read memory SHALL be synchronous, with dout registered: address issued in cycle t gives dout_r/dout_i/dout_valid in cycle t+1 (when sys_en=1 at t).
REQ-024 Latency: last input sample accepted at cycle T gives output index 0 with dout_valid=1 and dout_sof=1 at T+2, given sys_en continuously high.
REQ-025 sys_en=0: dout_valid, dout_sof and frame_drop SHALL be 0, rcnt/wcnt SHALL hold, and dout_r/dout_i SHALL hold their last values.
REQ-026 A frame completing during READ SHALL be queued (pending flag) and start immediately after the current read ends, with no gap cycle.
REQ-027 Since reads advance on every sys_en cycle and writes only on accepted ones, the bank being read SHALL never be overwritten.
REQ-028 Data SHALL pass bit-exact: no scaling, rounding or sign change.

Reset
REQ-029 On sys_clk with sys_nrst=0: wcnt=0, rcnt=0, bank select=0, pending=0, FSM=IDLE, and all outputs 0; bank contents are not cleared.
REQ-030 Reset asserted mid-frame or mid-read SHALL abort both, with no further dout_valid until a new complete frame is written.
REQ-031 Reset SHALL override sys_en.

Verification
REQ-032 fft_length=16, sys_en=1, din_valid=1, din_sof on the first sample, din_r=k for input index k=0..15 -> from T+2, dout_r sequence = bitrev4(n) for n=0..15 (0,8,4,12,...), with dout_sof on the first output only.
REQ-033 Back-to-back frames of 16, din_r = 100+k then 200+k -> 32 consecutive dout_valid cycles with no gap, and second-frame values begin exactly at output 16.
REQ-034 sys_en toggled 1,0 alternately through one frame -> identical output values; dout_valid never high while sys_en=0; dout holds.
REQ-035 din_sof asserted at wcnt=5 -> frame_drop pulses once; the following 16 samples output correctly; no output from the partial 5.
REQ-036 sys_nrst=0 for one cycle at output index 7 -> dout_valid=0 and dout_r=0 the next cycle; no output until a fresh full frame; then correct order.
REQ-037 fft_length=1024 random complex frame -> output equals the natural-order reference model, bit-exact on both rails.
